// File: rtl/mem_to_bram_arb.sv
// mem_to_bram_arb: round-robin arbiter that funnels N_LOAD elastic load
// channels onto BRAM port 0 (read-only) and one elastic store channel onto
// BRAM port 1 (write-only). Each load channel owns one result register that
// holds its response until the consumer takes it.
// Optional feature macro: MEM_TO_BRAM_ARB_FWD_EN. When defined, a load and a
// store issued in the same cycle to the same truncated address return the
// store data (store-before-load) instead of the BRAM's read-first old data.
module mem_to_bram_arb #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int N_LOAD          = 2,
  parameter int READ_LAT        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_LOAD-1:0]            ld_valid,
  output logic [N_LOAD-1:0]            ld_ready,
  input  logic [N_LOAD*ADDR_WIDTH-1:0] ld_addr,
  output logic [N_LOAD*DATA_WIDTH-1:0] ld_data,
  output logic [N_LOAD-1:0]            ld_data_valid,
  input  logic [N_LOAD-1:0]            ld_data_ready,
  input  logic                         st_valid,
  output logic                         st_ready,
  input  logic [ADDR_WIDTH-1:0]        st_addr,
  input  logic [DATA_WIDTH-1:0]        st_data,
  output logic                         ce0,
  output logic                         we0,
  output logic [BRAM_ADDR_WIDTH-1:0]   address0,
  input  logic [DATA_WIDTH-1:0]        din0,
  output logic                         ce1,
  output logic                         we1,
  output logic [BRAM_ADDR_WIDTH-1:0]   address1,
  output logic [DATA_WIDTH-1:0]        dout1
);

  localparam int ID_W = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;

  // Arbitration
  logic [N_LOAD-1:0]          w_inflight;
  logic [N_LOAD-1:0]          w_eligible;
  logic [N_LOAD-1:0]          w_ld_drain;
  logic                       w_grant_vld;
  logic [ID_W-1:0]            w_grant_id;
  logic [ID_W-1:0]            r_rr_ptr;

  // Tag pipe: one {valid, channel} entry per BRAM read-latency stage
  logic [READ_LAT-1:0]        r_pipe_vld;
  logic [ID_W-1:0]            r_pipe_id [READ_LAT];
  logic                       w_cap_vld;
  logic [ID_W-1:0]            w_cap_id;
  logic [DATA_WIDTH-1:0]      w_cap_data;

  // Per-channel result registers
  logic [N_LOAD-1:0]          r_ld_dv;
  logic [DATA_WIDTH-1:0]      r_ld_data [N_LOAD];

  // High address bits are dropped on purpose; fold them here so they count as consumed.
  logic                       w_unused_addr;
  assign w_unused_addr = ^{ld_addr, st_addr};

  // Wrap base+offset into the channel range (both operands are below N_LOAD).
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= N_LOAD) ? (s - N_LOAD) : s;
  endfunction

  // Mark channels that still have a read travelling through the tag pipe.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < N_LOAD; i++) begin
      for (int s = 0; s < READ_LAT; s++) begin
        if (r_pipe_vld[s] && (r_pipe_id[s] == ID_W'(i))) begin
          w_inflight[i] = 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_LOAD; gi++) begin : g_chan
      // A full result register may still accept a new load if it drains this cycle.
      assign w_ld_drain[gi]    = r_ld_dv[gi] & ld_data_ready[gi];
      assign w_eligible[gi]    = rst & ld_valid[gi] & ~w_inflight[gi] &
                                 (~r_ld_dv[gi] | w_ld_drain[gi]);
      assign ld_ready[gi]      = w_grant_vld & (w_grant_id == ID_W'(gi));
      assign ld_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_ld_data[gi];
    end
  endgenerate

  assign ld_data_valid = r_ld_dv;

  // Round-robin search from the pointer; first eligible channel wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int k = 0; k < N_LOAD; k++) begin
      if (!w_grant_vld && w_eligible[wrap_idx(int'(r_rr_ptr), k)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(wrap_idx(int'(r_rr_ptr), k));
      end
    end
  end

  // BRAM port 0 is driven straight from the grant, port 1 straight from the store channel.
  assign ce0      = w_grant_vld;
  assign we0      = 1'b0;
  assign address0 = w_grant_vld ? ld_addr[w_grant_id*ADDR_WIDTH +: BRAM_ADDR_WIDTH] : '0;
  assign st_ready = rst;
  assign ce1      = rst & st_valid;
  assign we1      = rst & st_valid;
  assign address1 = st_addr[BRAM_ADDR_WIDTH-1:0];
  assign dout1    = st_data;

  // Pointer moves past the granted channel only when a grant happens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant_vld) begin
      r_rr_ptr <= (w_grant_id == ID_W'(N_LOAD-1)) ? '0 : w_grant_id + 1'b1;
    end
  end

  // Shift the grant tag along with the BRAM read latency.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        r_pipe_id[s] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_grant_vld;
      r_pipe_id[0]  <= w_grant_id;
      for (int s = 1; s < READ_LAT; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_id[s]  <= r_pipe_id[s-1];
      end
    end
  end

  assign w_cap_vld = r_pipe_vld[READ_LAT-1];
  assign w_cap_id  = r_pipe_id[READ_LAT-1];

`ifdef MEM_TO_BRAM_ARB_FWD_EN
  logic                  w_fwd_hit;
  logic [READ_LAT-1:0]   r_pipe_fwd;
  logic [DATA_WIDTH-1:0] r_pipe_fdata [READ_LAT];

  assign w_fwd_hit  = w_grant_vld & ce1 & (address0 == address1);
  assign w_cap_data = r_pipe_fwd[READ_LAT-1] ? r_pipe_fdata[READ_LAT-1] : din0;

  // Carry the forward flag and captured store data alongside the tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe_fwd <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        r_pipe_fdata[s] <= '0;
      end
    end else begin
      r_pipe_fwd[0]   <= w_fwd_hit;
      r_pipe_fdata[0] <= st_data;
      for (int s = 1; s < READ_LAT; s++) begin
        r_pipe_fwd[s]   <= r_pipe_fwd[s-1];
        r_pipe_fdata[s] <= r_pipe_fdata[s-1];
      end
    end
  end
`else
  assign w_cap_data = din0;
`endif

  // Land returning read data in the owner's result register; clear on handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ld_dv <= '0;
      for (int i = 0; i < N_LOAD; i++) begin
        r_ld_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_LOAD; i++) begin
        if (w_cap_vld && (w_cap_id == ID_W'(i))) begin
          r_ld_dv[i]   <= 1'b1;
          r_ld_data[i] <= w_cap_data;
        end else if (w_ld_drain[i]) begin
          r_ld_dv[i]   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_to_bram_arb.sv
// Testbench for mem_to_bram_arb: directed scenarios followed by random traffic,
// all checked every cycle against a transaction-level model (per-channel
// countdown to response, round-robin pointer, and a shadow copy of BRAM).
module tb_mem_to_bram_arb;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BAW = 10;
  localparam int NL  = 2;
  localparam int RL  = 1;

  logic             clk;
  logic             rst;
  logic [NL-1:0]    ld_valid;
  logic [NL-1:0]    ld_ready;
  logic [NL*AW-1:0] ld_addr;
  logic [NL*DW-1:0] ld_data;
  logic [NL-1:0]    ld_data_valid;
  logic [NL-1:0]    ld_data_ready;
  logic             st_valid;
  logic             st_ready;
  logic [AW-1:0]    st_addr;
  logic [DW-1:0]    st_data;
  logic             ce0, we0, ce1, we1;
  logic [BAW-1:0]   address0, address1;
  logic [DW-1:0]    din0, dout1;

  // Bench-side BRAM preload port
  logic             tb_wr_en;
  logic [BAW-1:0]   tb_wr_addr;
  logic [DW-1:0]    tb_wr_data;

  int n_checks;
  int n_errors;

  // Reference model state
  logic [DW-1:0]    mmem [0:(1<<BAW)-1];
  logic [NL-1:0]    m_dv;
  logic [DW-1:0]    m_data [NL];
  logic [DW-1:0]    m_pend [NL];
  int               m_cnt  [NL];
  int               m_rr;

  mem_to_bram_arb #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BRAM_ADDR_WIDTH(BAW),
    .N_LOAD(NL), .READ_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_data_valid(ld_data_valid), .ld_data_ready(ld_data_ready),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ce0(ce0), .we0(we0), .address0(address0), .din0(din0),
    .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Dual-port BRAM, read-first, READ_LAT cycles of read latency
  logic [DW-1:0] bram [0:(1<<BAW)-1];
  logic [DW-1:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (ce0) rd_pipe[0] <= bram[address0];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (ce1 && we1) bram[address1] <= dout1;
    if (tb_wr_en) bram[tb_wr_addr] <= tb_wr_data;
  end
  assign din0 = rd_pipe[RL-1];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom & 32'hFFFF_FC00) | $urandom_range(0, 15);
  endfunction

  // Check this cycle's outputs against the model, then advance the model over the clock edge.
  task automatic tick();
    int g;
    logic [NL-1:0]  exp_rdy;
    logic [BAW-1:0] a;
    #4;
    g = -1;
    for (int k = 0; k < NL; k++) begin
      int c;
      c = (m_rr + k) % NL;
      if (g < 0 && rst && ld_valid[c] && m_cnt[c] == 0 && (!m_dv[c] || ld_data_ready[c])) g = c;
    end
    exp_rdy = (g >= 0) ? (NL'(1) << g) : '0;
    check_eq("ld_ready", 64'(ld_ready), 64'(exp_rdy));
    check_eq("ce0", 64'(ce0), 64'(g >= 0));
    check_eq("we0", 64'(we0), 64'(0));
    if (g >= 0) check_eq("address0", 64'(address0), 64'(ld_addr[g*AW +: BAW]));
    check_eq("st_ready", 64'(st_ready), 64'(rst));
    check_eq("ce1", 64'(ce1), 64'(rst && st_valid));
    check_eq("we1", 64'(we1), 64'(rst && st_valid));
    if (rst && st_valid) begin
      check_eq("address1", 64'(address1), 64'(st_addr[BAW-1:0]));
      check_eq("dout1", 64'(dout1), 64'(st_data));
    end
    check_eq("ld_data_valid", 64'(ld_data_valid), 64'(m_dv));
    for (int i = 0; i < NL; i++)
      if (m_dv[i]) check_eq($sformatf("ld_data[%0d]", i), 64'(ld_data[i*DW +: DW]), 64'(m_data[i]));

    if (!rst) begin
      m_dv = '0;
      m_rr = 0;
      for (int i = 0; i < NL; i++) begin m_cnt[i] = 0; m_data[i] = '0; end
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (m_dv[i] && ld_data_ready[i]) begin
          $display("load   ch%0d data %h", i, m_data[i]);
          m_dv[i] = 1'b0;
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin m_dv[i] = 1'b1; m_data[i] = m_pend[i]; end
        end
      end
      if (g >= 0) begin
        a = ld_addr[g*AW +: BAW];
        m_pend[g] = mmem[a];
`ifdef MEM_TO_BRAM_ARB_FWD_EN
        if (st_valid && st_addr[BAW-1:0] == a) m_pend[g] = st_data;
`endif
        m_cnt[g] = RL;
        m_rr = (g + 1) % NL;
      end
      if (st_valid) begin
        mmem[st_addr[BAW-1:0]] = st_data;
        $display("store  addr %0d data %h", st_addr[BAW-1:0], st_data);
      end
    end
    if (tb_wr_en) mmem[tb_wr_addr] = tb_wr_data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ld_valid = '0; st_valid = 1'b0; ld_data_ready = '1;
    repeat (n) tick();
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_dv = '0; m_rr = 0;
    for (int i = 0; i < NL; i++) begin m_cnt[i] = 0; m_data[i] = '0; m_pend[i] = '0; end
    rst = 1'b0; ld_valid = '1; ld_data_ready = '1; st_valid = 1'b0;
    st_addr = '0; st_data = '0; tb_wr_en = 1'b0; tb_wr_addr = '0; tb_wr_data = '0;
    for (int i = 0; i < NL; i++) ld_addr[i*AW +: AW] = rnd_addr();
    @(posedge clk); #1;

    // Reset held with all loads requesting, BRAM preloaded meanwhile
    for (int a = 0; a < 16; a++) begin
      tb_wr_en = 1'b1; tb_wr_addr = BAW'(a); tb_wr_data = $urandom;
      tick();
    end
    tb_wr_en = 1'b0;
    rst = 1'b1;
    idle(2);

    // Single load from a preloaded word, high address bits set
    tb_wr_en = 1'b1; tb_wr_addr = 10'd5; tb_wr_data = 32'hDEADBEEF;
    tick();
    tb_wr_en = 1'b0;
    ld_valid = 2'b01; ld_addr[0 +: AW] = 32'hABC0_0005;
    tick();
    ld_valid = '0;
    repeat (RL) tick();
    check_eq("single_dv", 64'(ld_data_valid[0]), 64'(1));
    check_eq("single_data", 64'(ld_data[0 +: DW]), 64'(32'hDEADBEEF));
    idle(3);

    // Fairness: both channels always requesting, consumer always ready
    ld_valid = '1; ld_data_ready = '1;
    for (int i = 0; i < NL; i++) ld_addr[i*AW +: AW] = rnd_addr();
    repeat (8) tick();

    // Backpressure on channel 1
    ld_data_ready = 2'b01;
    repeat (10) tick();
    idle(4);

    // Same-cycle load and store to one address
    tb_wr_en = 1'b1; tb_wr_addr = 10'd7; tb_wr_data = 32'h22;
    tick();
    tb_wr_en = 1'b0;
    ld_valid = 2'b01; ld_addr[0 +: AW] = 32'h0000_0007;
    st_valid = 1'b1; st_addr = 32'h0001_0007; st_data = 32'h11;
    tick();
    ld_valid = '0; st_valid = 1'b0; ld_data_ready = '0;
    repeat (RL) tick();
`ifdef MEM_TO_BRAM_ARB_FWD_EN
    check_eq("collision_data", 64'(ld_data[0 +: DW]), 64'(32'h11));
`else
    check_eq("collision_data", 64'(ld_data[0 +: DW]), 64'(32'h22));
`endif
    idle(3);

    // Reset one cycle after a grant discards the response
    ld_valid = 2'b10; ld_addr[AW +: AW] = rnd_addr();
    tick();
    rst = 1'b0; ld_valid = '0;
    tick();
    rst = 1'b1;
    idle(RL + 2);
    check_eq("reset_flight_dv", 64'(ld_data_valid), 64'(0));

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 149) != 0);
      ld_valid      = NL'($urandom);
      ld_data_ready = NL'($urandom | $urandom);
      st_valid      = $urandom_range(0, 1) == 1;
      st_addr       = rnd_addr();
      st_data       = $urandom;
      for (int i = 0; i < NL; i++) ld_addr[i*AW +: AW] = rnd_addr();
      tick();
    end
    rst = 1'b1;
    idle(RL + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
